// File: rtl/instr_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_pkg
// Shared constants for the front end: instruction width, default address
// width, the fetch FSM state type and the base opcode constants that the
// control decoder matches against the fetched instruction.
// -----------------------------------------------------------------------------
package instr_fetch_pkg;

    localparam int INSTR_LEN    = 32;
    localparam int PC_WIDTH_DEF = 32;

    // S_FETCH: no request outstanding
    // S_WAIT : one request outstanding, its data will be queued
    // S_FLUSH: one request outstanding, its data will be discarded
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_FLUSH = 2'd2
    } fetch_state_t;

    // Base opcodes (instr[6:0]) seen by the control decoder.
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_JAL    = 7'h6F;

endpackage

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Small FIFO of {pc, instruction} pairs between the fetch FSM and decode.
// The head is presented from storage only, so nothing on the memory read
// data path reaches the outputs combinationally. Empty head reads as zero.
//
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write {push_pc, push_data} at the tail
//   pop         : remove the head (caller qualifies with head_valid)
//   flush       : empty the queue; wins over push and pop
//   head_valid  : queue is not empty
//   head_pc     : pc of the head entry, zero when empty
//   head_data   : instruction of the head entry, zero when empty
//   count       : number of valid entries
// -----------------------------------------------------------------------------
module fetch_queue
    import instr_fetch_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int PC_W   = PC_WIDTH_DEF,
    parameter int DATA_W = INSTR_LEN
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [PC_W-1:0]            push_pc,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic                       head_valid,
    output logic [PC_W-1:0]            head_pc,
    output logic [DATA_W-1:0]          head_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // NOTE: every variable gets its hold value before any branch, so no
    // path through the block leaves one unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap by overflow.
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples values from before the edge, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array has no reset; an entry is only ever read
    // after it has been written, and the head outputs are zeroed when empty.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= {push_pc, push_data};
        end
    end

    assign head_valid = (count_q != '0);
    assign head_pc    = head_valid ? mem_q[rd_ptr_q].pc   : '0;
    assign head_data  = head_valid ? mem_q[rd_ptr_q].data : '0;
    assign count      = count_q;

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Instruction fetch unit: issues word-aligned fetches to instruction memory,
// keeps at most one request in flight, queues returned instructions with
// their pc and hands them to decode through a valid/ready handshake.
// A redirect empties the queue and restarts fetching at the new target;
// data of a request issued before the redirect is discarded.
//
// Ports
//   clk, rst_n      : clock, asynchronous active-low reset
//   imem_req        : one-cycle fetch request at imem_addr
//   imem_addr       : fetch address (current pc)
//   imem_rvalid     : read data valid, one pulse per request
//   imem_rdata      : fetched instruction
//   instr_valid     : queue head valid for decode
//   instr           : queue-head instruction, zero when not valid
//   instr_pc        : address of instr, zero when not valid
//   instr_ready     : decode accepts the head
//   redirect_valid  : taken branch, flush and refetch
//   redirect_pc     : new fetch address (low two bits ignored)
// -----------------------------------------------------------------------------
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                  PC_WIDTH    = PC_WIDTH_DEF,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter int                  QUEUE_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 imem_req,
    output logic [PC_WIDTH-1:0]  imem_addr,
    input  logic                 imem_rvalid,
    input  logic [INSTR_LEN-1:0] imem_rdata,
    output logic                 instr_valid,
    output logic [INSTR_LEN-1:0] instr,
    output logic [PC_WIDTH-1:0]  instr_pc,
    input  logic                 instr_ready,
    input  logic                 redirect_valid,
    input  logic [PC_WIDTH-1:0]  redirect_pc
);

    localparam int                  CNT_W      = $clog2(QUEUE_DEPTH+1);
    localparam logic [PC_WIDTH-1:0] WORD_MASK  = ~PC_WIDTH'(3);
    localparam logic [PC_WIDTH-1:0] RESET_ADDR = RESET_PC & WORD_MASK;

    fetch_state_t         state_q, state_d;
    logic [PC_WIDTH-1:0]  pc_q, pc_d;
    logic [PC_WIDTH-1:0]  req_pc_q, req_pc_d;   // pc of the request in flight

    logic [CNT_W-1:0]     q_count;
    logic                 q_push, q_pop;
    logic [CNT_W:0]       occupancy;
    logic                 has_room;
    logic                 issue;

    // A slot is reserved when a request issues: occupancy counts what the
    // queue will hold after this edge, so a response can never find it full
    // and a pop this cycle frees room for back-to-back fetches.
    always_comb begin
        q_pop     = instr_valid && instr_ready;
        q_push    = (state_q == S_WAIT) && imem_rvalid && !redirect_valid;
        occupancy = {1'b0, q_count} + (CNT_W+1)'(q_push) - (CNT_W+1)'(q_pop);
        has_room  = occupancy < (CNT_W+1)'(QUEUE_DEPTH);
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        issue    = 1'b0;
        case (state_q)
            // A response here has no matching request and is ignored.
            S_FETCH: issue = !redirect_valid && has_room;
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_d = S_FETCH;
                    issue   = !redirect_valid && has_room;
                end else if (redirect_valid) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (imem_rvalid) state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        if (issue) begin
            state_d  = S_WAIT;
            req_pc_d = pc_q;
            pc_d     = pc_q + PC_WIDTH'(4);
        end
        if (redirect_valid) begin
            pc_d = redirect_pc & WORD_MASK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_ADDR;
            req_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    // The FSM sits in S_FETCH with room during reset; gating with rst_n keeps
    // the request low while reset is held and lets the first request be
    // taken on the first edge after release.
    assign imem_req  = issue && rst_n;
    assign imem_addr = pc_q;

    fetch_queue #(
        .DEPTH  (QUEUE_DEPTH),
        .PC_W   (PC_WIDTH),
        .DATA_W (INSTR_LEN)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (q_push),
        .push_pc    (req_pc_q),
        .push_data  (imem_rdata),
        .pop        (q_pop),
        .flush      (redirect_valid),
        .head_valid (instr_valid),
        .head_pc    (instr_pc),
        .head_data  (instr),
        .count      (q_count)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Directed bench for instr_fetch: a cycle table for streaming, back-pressure
// and redirects with a 1-cycle memory, hand-written sequences for flushes with
// a 3-cycle memory, asynchronous reset mid-request, and a second instance with
// RESET_PC near the top of the address space to check pc wrap.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_rvalid;
    logic [31:0] w_rdata;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [31:0] w_pc;
    logic        w_ready;
    logic        w_redirect;
    logic [31:0] w_redirect_pc;

    int errors = 0;
    int checks = 0;

    instr_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (w_req),
        .imem_addr      (w_addr),
        .imem_rvalid    (w_rvalid),
        .imem_rdata     (w_rdata),
        .instr_valid    (w_valid),
        .instr          (w_instr),
        .instr_pc       (w_pc),
        .instr_ready    (w_ready),
        .redirect_valid (w_redirect),
        .redirect_pc    (w_redirect_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory content: a recognisable word derived from the address.
    function automatic logic [31:0] mdata(input logic [31:0] a);
        return {a[23:0], 8'h13};
    endfunction

    // ---------------- memory model, main instance (latency = lat) ----------
    int          lat = 1;
    logic        pend;
    int          cnt;
    logic [31:0] paddr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_rvalid <= 1'b0;
            imem_rdata  <= '0;
            pend        <= 1'b0;
            cnt         <= 0;
            paddr       <= '0;
        end else begin
            imem_rvalid <= 1'b0;
            if (pend) begin
                if (cnt == 1) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= mdata(paddr);
                    pend        <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end
            if (imem_req) begin
                if (lat <= 1) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= mdata(imem_addr);
                end else begin
                    pend  <= 1'b1;
                    cnt   <= lat - 1;
                    paddr <= imem_addr;
                end
            end
        end
    end

    // Count requests issued while another is still in flight.
    logic outst;
    int   viol = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outst <= 1'b0;
        end else begin
            if (imem_req && outst && !imem_rvalid) viol <= viol + 1;
            if (imem_req)         outst <= 1'b1;
            else if (imem_rvalid) outst <= 1'b0;
        end
    end

    // ---------------- wrap instance: 1-cycle memory, always ready ----------
    logic [31:0] w_addrs [3];
    logic [31:0] w_pcs   [3];
    logic [31:0] w_words [3];
    int          w_n  = 0;
    int          w_pn = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_rvalid <= 1'b0;
            w_rdata  <= '0;
        end else begin
            w_rvalid <= w_req;
            w_rdata  <= mdata(w_addr);
            if (w_req && w_n < 3) begin
                w_addrs[w_n] <= w_addr;
                w_n          <= w_n + 1;
            end
            if (w_valid && w_pn < 3) begin
                w_pcs[w_pn]   <= w_pc;
                w_words[w_pn] <= w_instr;
                w_pn          <= w_pn + 1;
            end
        end
    end

    // ---------------- helpers ----------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Leaves time at one unit after a falling edge: drive, wait #1, sample.
    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic apply_reset(input int l);
        rst_n          = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        lat            = l;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- cycle table ------------------------------------------
    typedef struct {
        logic        rst;
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic ready, input logic redir,
                       input logic [31:0] rpc, input logic ereq, input logic [31:0] eaddr,
                       input logic evalid, input logic [31:0] epc);
        vec_t t;
        t.rst = rst;       t.ready = ready;     t.redir = redir;     t.rpc = rpc;
        t.exp_req = ereq;  t.exp_addr = eaddr;  t.exp_valid = evalid; t.exp_pc = epc;
        vecs.push_back(t);
    endtask

    // Redirect to 0x10, then redirect again (once or twice) while that fetch
    // is in flight; the 0x10 data must never appear and fetch resumes at target.
    task automatic seq_flush(input string tag, input bit dbl, input logic [31:0] target);
        bit          found = 0;
        bit          got   = 0;
        bit          stale = 0;
        logic [31:0] first_addr = '0;
        logic [31:0] seen_pc = '0;
        logic [31:0] seen_instr = '0;

        apply_reset(3);
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        #1;
        check({tag, "_redir_noreq"}, 32'(imem_req), 32'd0);
        next_cycle();
        redirect_valid = 1'b0;
        #1;
        check({tag, "_req10"}, 32'(imem_req), 32'd1);
        check({tag, "_addr10"}, imem_addr, 32'h10);
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        #1;
        check({tag, "_wait_redir_noreq"}, 32'(imem_req), 32'd0);
        next_cycle();
        if (dbl) begin
            redirect_pc = 32'h203;
            #1;
            check({tag, "_flush_redir_noreq"}, 32'(imem_req), 32'd0);
            next_cycle();
        end
        redirect_valid = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            #1;
            if (instr_valid && instr_pc == 32'h10) stale = 1'b1;
            if (imem_req) begin
                found      = 1'b1;
                first_addr = imem_addr;
            end else begin
                next_cycle();
            end
        end
        check({tag, "_req_seen"}, 32'(found), 32'd1);
        check({tag, "_first_addr"}, first_addr, target);
        for (int i = 0; i < 12 && !got; i++) begin
            next_cycle();
            if (instr_valid && instr_pc == 32'h10) stale = 1'b1;
            if (instr_valid) begin
                got        = 1'b1;
                seen_pc    = instr_pc;
                seen_instr = instr;
            end
        end
        check({tag, "_stale_dropped"}, 32'(stale), 32'd0);
        check({tag, "_valid_seen"}, 32'(got), 32'd1);
        check({tag, "_head_pc"}, seen_pc, target);
        check({tag, "_head_instr"}, seen_instr, mdata(target));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          nreq;
        bit          found;
        logic [31:0] got_addr;

        rst_n          = 1'b1;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        w_ready        = 1'b1;
        w_redirect     = 1'b0;
        w_redirect_pc  = '0;

        // Reset state, observed asynchronously before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_wrap_addr", w_addr, 32'hFFFF_FFF8);

        // rst ready redir rpc     | req addr      valid pc
        add(1, 1, 0, 32'h0,   1, 32'h0,   0, 32'h0);
        add(0, 1, 0, 32'h0,   1, 32'h4,   0, 32'h0);
        add(0, 1, 0, 32'h0,   1, 32'h8,   1, 32'h0);
        add(0, 1, 0, 32'h0,   1, 32'hC,   1, 32'h4);
        add(0, 1, 0, 32'h0,   1, 32'h10,  1, 32'h8);
        add(0, 0, 0, 32'h0,   0, 32'h14,  1, 32'hC);
        add(0, 0, 0, 32'h0,   0, 32'h14,  1, 32'hC);
        add(0, 1, 0, 32'h0,   1, 32'h14,  1, 32'hC);
        add(0, 1, 0, 32'h0,   1, 32'h18,  1, 32'h10);
        add(0, 0, 0, 32'h0,   0, 32'h1C,  1, 32'h14);
        add(0, 0, 1, 32'h103, 0, 32'h1C,  1, 32'h14);
        add(0, 1, 0, 32'h0,   1, 32'h100, 0, 32'h0);
        add(0, 1, 0, 32'h0,   1, 32'h104, 0, 32'h0);
        add(0, 1, 0, 32'h0,   1, 32'h108, 1, 32'h100);
        add(0, 1, 1, 32'h200, 0, 32'h10C, 1, 32'h104);
        add(0, 1, 0, 32'h0,   1, 32'h200, 0, 32'h0);
        add(0, 1, 0, 32'h0,   1, 32'h204, 0, 32'h0);
        add(0, 1, 0, 32'h0,   1, 32'h208, 1, 32'h200);

        foreach (vecs[i]) begin
            if (vecs[i].rst) apply_reset(1);
            instr_ready    = vecs[i].ready;
            redirect_valid = vecs[i].redir;
            redirect_pc    = vecs[i].rpc;
            #1;
            check($sformatf("row%0d_req", i), 32'(imem_req), 32'(vecs[i].exp_req));
            check($sformatf("row%0d_addr", i), imem_addr, vecs[i].exp_addr);
            check($sformatf("row%0d_valid", i), 32'(instr_valid), 32'(vecs[i].exp_valid));
            check($sformatf("row%0d_instr_pc", i), instr_pc, vecs[i].exp_pc);
            check($sformatf("row%0d_instr", i), instr,
                  vecs[i].exp_valid ? mdata(vecs[i].exp_pc) : 32'h0);
            next_cycle();
        end
        redirect_valid = 1'b0;

        // Back-pressure: depth 2 allows exactly two requests, then resumes at 8.
        apply_reset(1);
        nreq = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (imem_req) nreq++;
            next_cycle();
        end
        check("bp_req_count", 32'(nreq), 32'd2);
        check("bp_head_pc", instr_pc, 32'h0);
        instr_ready = 1'b1;
        found    = 1'b0;
        got_addr = '0;
        for (int i = 0; i < 4 && !found; i++) begin
            #1;
            if (imem_req) begin
                found    = 1'b1;
                got_addr = imem_addr;
            end else begin
                next_cycle();
            end
        end
        check("bp_resume_seen", 32'(found), 32'd1);
        check("bp_resume_addr", got_addr, 32'h8);

        // Redirect during an outstanding 3-cycle fetch, and again while flushing.
        seq_flush("flush", 1'b0, 32'h100);
        seq_flush("flush2", 1'b1, 32'h200);

        // Asynchronous reset while a request is in flight and the queue is full.
        apply_reset(1);
        next_cycle();
        next_cycle();
        check("arst_pre_valid", 32'(instr_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_req", 32'(imem_req), 32'd0);
        check("arst_addr", imem_addr, 32'h0);
        check("arst_valid", 32'(instr_valid), 32'd0);
        check("arst_instr", instr, 32'h0);
        check("arst_instr_pc", instr_pc, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("arst_first_req", 32'(imem_req), 32'd1);
        check("arst_first_addr", imem_addr, 32'h0);
        next_cycle();
        next_cycle();
        check("arst_no_stale", instr_pc, 32'h0);
        check("arst_instr_after", instr, mdata(32'h0));

        // Wrap instance: first three requests and deliveries after first reset.
        check("wrap_req_count", 32'(w_n), 32'd3);
        check("wrap_addr0", w_addrs[0], 32'hFFFF_FFF8);
        check("wrap_addr1", w_addrs[1], 32'hFFFF_FFFC);
        check("wrap_addr2", w_addrs[2], 32'h0);
        check("wrap_pc0", w_pcs[0], 32'hFFFF_FFF8);
        check("wrap_pc2", w_pcs[2], 32'h0);
        check("wrap_instr0", w_words[0], mdata(32'hFFFF_FFF8));

        check("single_outstanding", 32'(viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter PC_WIDTH, default 32, instruction address width in bits.
REQ-002 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-003 Parameter QUEUE_DEPTH, default 2, fetch-queue entries; legal values are 2 and 4.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 imem_req  output  1  one-cycle pulse requesting a fetch at imem_addr.
REQ-007 imem_addr  output  PC_WIDTH  fetch address, word aligned.
REQ-008 imem_rvalid  input  1  read data valid, exactly one pulse per request, latency of at least 1 cycle.
REQ-009 imem_rdata  input  INSTR_LEN  fetched instruction.
REQ-010 instr_valid  output  1  queue head holds a valid instruction for decode.
REQ-011 instr  output  INSTR_LEN  queue-head instruction, drives the control decoder.
REQ-012 instr_pc  output  PC_WIDTH  address of instr.
REQ-013 instr_ready  input  1  decode accepts the head; a transfer occurs when instr_valid and instr_ready are both 1.
REQ-014 redirect_valid  input  1  branch taken; flush the queue and refetch.
REQ-015 redirect_pc  input  PC_WIDTH  new fetch address.

Function
REQ-016 At most one imem request shall be outstanding at any time.
REQ-017 FSM states: S_FETCH (no request outstanding), S_WAIT (awaiting rvalid), S_FLUSH (awaiting an rvalid that will be discarded).
REQ-018 S_FETCH: if count plus accepted-this-cycle is less than QUEUE_DEPTH, pulse imem_req with imem_addr=pc, set pc=pc+4, and go to S_WAIT; otherwise hold.
REQ-019 S_WAIT on rvalid: push {pc_of_req, imem_rdata}. The FSM may issue the next request in the same cycle under the REQ-018 rule, so a 1-cycle memory sustains 1 instruction per cycle.
REQ-020 Push occurs at edge N; instr_valid is high from cycle N+1. There is no combinational path from imem_rdata to instr.
REQ-021 Queue is FIFO ordered, and push and pop may occur in the same cycle. A slot is reserved at request issue, so a push to a full queue cannot occur.
REQ-022 When instr_valid=0, instr and instr_pc shall be all-zeros.
REQ-023 redirect_valid: empty the queue, set pc={redirect_pc[PC_WIDTH-1:2],2'b00}, and pulse no request in that cycle.
REQ-024 Redirect while in S_WAIT with rvalid low: go to S_FLUSH; the next rvalid is dropped; then go to S_FETCH.
REQ-025 Redirect in the same cycle as rvalid: drop the data and go to S_FETCH.
REQ-026 Redirect in the same cycle as a handshake: the dequeue completes and the queue is still emptied.
REQ-027 Redirect while in S_FLUSH: update pc and remain in S_FLUSH.
REQ-028 pc wraps modulo 2^PC_WIDTH.
REQ-029 An rvalid arriving in S_FETCH is a protocol error: ignore it and keep state unchanged.

Reset
REQ-030 On rst_n low: imem_req=0, imem_addr=RESET_PC, pc=RESET_PC, instr_valid=0, instr=0, instr_pc=0, count=0, state=S_FETCH.
REQ-031 Reset mid-request abandons the outstanding fetch. The memory side is reset by the same rst_n, so no stale rvalid follows.
REQ-032 The first imem_req occurs in the first clk edge after rst_n deasserts.

Structure
REQ-033 INSTR_LEN, PC_WIDTH default, and the fetch_state_t enum are defined in the shared constants package/header alongside the opcode constants.
REQ-034 Sub-module fetch_queue is a parameterised FIFO of {pc, instr} with count, push, pop and flush, instantiated once.
REQ-035 The output of instr_fetch connects directly to the instr input of control, with no intermediate logic.

Verification
REQ-036 Reset release, 1-cycle memory, instr_ready=1 -> imem_addr sequence 0,4,8,12; instr_valid from cycle 3; one instr per cycle; instr_pc is 0,4,8.
REQ-037 instr_ready=0 with QUEUE_DEPTH=2 -> exactly 2 requests issue, then imem_req stays low. instr_ready=1 -> fetch resumes at address 8.
REQ-038 Redirect to 0x103 while a 3-cycle-latency fetch of 0x10 is outstanding -> the 0x10 data is never presented; the next request is 0x100.
REQ-039 Redirect in the same cycle as rvalid -> data dropped, queue empty, next imem_addr is the redirect target.
REQ-040 RESET_PC=0xFFFFFFF8 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0.
REQ-041 rst_n asserted mid-S_WAIT -> all outputs match REQ-030 asynchronously; the first request after release is RESET_PC.
